// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Shares one uart_tx serialiser between NUM_REQ byte producers. One byte is
//   granted per arbitration, in round-robin order. The arbiter alone drives
//   the serialiser's data_in/send and watches its ready, so producers never
//   touch that handshake themselves.
//
// Parameters:
//   NUM_REQ    number of requesters (2..8)
//   ID_W       width of grant_id / round-robin pointer, clog2(NUM_REQ)
//
// Ports:
//   clk        in   1           system clock
//   rst_n      in   1           asynchronous active-low reset
//   req_valid  in   NUM_REQ     requester i has a byte pending
//   req_data   in   NUM_REQ*8   byte of requester i on [8*i+7:8*i]
//   req_last   in   NUM_REQ     last byte of a packet (packet-lock build only)
//   req_ready  out  NUM_REQ     one-cycle, one-hot accept pulse
//   tx_data    out  8           to uart_tx data_in
//   tx_send    out  1           to uart_tx send
//   tx_ready   in   1           from uart_tx ready
//   grant_id   out  ID_W        index of the most recently granted requester
//   busy       out  1           high whenever the FSM is not in IDLE
//
// Build option:
//   UART_ARB_LOCK_EN  when defined, a byte granted with req_last=0 locks the
//                     arbiter onto that requester until it sends a byte with
//                     req_last=1, so packets are never interleaved.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_send,
    input  logic                 tx_ready,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy
);

    localparam logic [ID_W-1:0]    LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      grant_q, grant_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_send_q, tx_send_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;

    logic [NUM_REQ-1:0]   eligible;
    logic                 found;
    logic [ID_W-1:0]      winner;
    logic [7:0]           win_data;
    logic                 win_last;

`ifdef UART_ARB_LOCK_EN
    logic                 lock_q, lock_d;

    // While a packet is in flight only the locked requester may win. The
    // locked requester is always the last one granted, which is exactly
    // where the round-robin pointer sits, so the pointer doubles as lock id.
    always_comb begin
        eligible = req_valid;
        if (lock_q) begin
            eligible = req_valid & (ONE_HOT << ptr_q);
        end
    end
`else
    logic                 unused_last;

    // Without packet locking every valid requester competes on every byte
    // and the packet markers carry no meaning.
    always_comb begin
        eligible = req_valid;
    end

    assign unused_last = ^req_last;
`endif

    // Round-robin search: start one past the last winner and walk upward.
    // The wrap is an explicit compare so non-power-of-two NUM_REQ works.
    always_comb begin
        logic [ID_W-1:0] cand;
        found  = 1'b0;
        winner = '0;
        cand   = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (cand == LAST_ID) begin
                cand = '0;
            end else begin
                cand = cand + 1'b1;
            end
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Select the winning requester's byte and packet marker.
    always_comb begin
        win_data = 8'h00;
        win_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_data = req_data[8*i +: 8];
                win_last = req_last[i];
            end
        end
    end

    // Next-state and output logic. Requests are only looked at in IDLE, so a
    // producer that has not yet dropped its valid after req_ready can never
    // be granted twice for the same byte.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        tx_data_d   = tx_data_q;
        tx_send_d   = tx_send_q;
        req_ready_d = '0;
`ifdef UART_ARB_LOCK_EN
        lock_d      = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_ready && found) begin
                    tx_data_d   = win_data;
                    tx_send_d   = 1'b1;
                    req_ready_d = ONE_HOT << winner;
                    grant_d     = winner;
                    ptr_d       = winner;
                    state_d     = SEND;
`ifdef UART_ARB_LOCK_EN
                    lock_d      = !win_last;
`endif
                end
            end
            SEND: begin
                // The serialiser drops ready once it has taken the byte.
                if (!tx_ready) begin
                    tx_send_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                tx_send_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers. Reset parks the pointer on the last index
    // so requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= LAST_ID;
            grant_q     <= '0;
            tx_data_q   <= 8'h00;
            tx_send_q   <= 1'b0;
            req_ready_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            tx_data_q   <= tx_data_d;
            tx_send_q   <= tx_send_d;
            req_ready_q <= req_ready_d;
        end
    end

`ifdef UART_ARB_LOCK_EN
    // Packet lock register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    assign req_ready = req_ready_q;
    assign tx_data   = tx_data_q;
    assign tx_send   = tx_send_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != IDLE);

endmodule
